// File: rtl/gray_pkg.sv
// Gray/binary conversion helpers shared by Gray counters and async FIFO
// pointer logic. Values are carried in 32-bit containers, w gives live bits.
package gray_pkg;

    localparam int GRAY_MAX_WIDTH = 32;

    // Mask with the low w bits set; w outside 1..32 saturates to 32.
    function automatic logic [31:0] gray_mask(input int w);
        logic [31:0] m;
        if (w >= GRAY_MAX_WIDTH || w <= 0) begin
            m = '1;
        end else begin
            m = (32'd1 << w) - 32'd1;
        end
        return m;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b,
                                             input int w);
        logic [31:0] bm;
        bm = b & gray_mask(w);
        return bm ^ (bm >> 1);
    endfunction

    // bin[i] = XOR of gray[MSB:i]; bits above w are zeroed first so
    // they cannot leak into the prefix XOR.
    function automatic logic [31:0] gray2bin(input logic [31:0] g,
                                             input int w);
        logic [31:0] gm;
        logic [31:0] b;
        gm = g & gray_mask(w);
        b = '0;
        b[GRAY_MAX_WIDTH-1] = gm[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ gm[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_updown_counter.sv
// Up/down Gray counter with clear, Gray load and wrap/saturate boundary.
// Ports: clk, resetn, en, up, clr, load, load_gray -> gray_out, bin_out,
//        at_min, at_max, bound (all outputs registered, 1-cycle latency).
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             at_min,
    output logic             at_max,
    output logic             bound
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH:0]   ONE     = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nxt_bin;
    logic             nxt_bound;

    assign load_bin = WIDTH'(gray2bin(32'(load_gray), WIDTH));

    // The extra MSB of sum is the carry (up) or borrow (down); in wrap
    // mode it flags the wrap, in saturate mode the stored flags decide.
    always_comb begin
        nxt_bin   = bin_out;
        nxt_bound = 1'b0;
        sum       = up ? ({1'b0, bin_out} + ONE) : ({1'b0, bin_out} - ONE);
        if (clr) begin
            nxt_bin = '0;
        end else if (load) begin
            nxt_bin = load_bin;
        end else if (en) begin
            if (WRAP) begin
                nxt_bin   = sum[WIDTH-1:0];
                nxt_bound = sum[WIDTH];
            end else if (up ? at_max : at_min) begin
                nxt_bound = 1'b1;
            end else begin
                nxt_bin = sum[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bin_out  <= '0;
            gray_out <= '0;
            at_min   <= 1'b1;
            at_max   <= 1'b0;
            bound    <= 1'b0;
        end else begin
            bin_out  <= nxt_bin;
            gray_out <= WIDTH'(bin2gray(32'(nxt_bin), WIDTH));
            at_min   <= (nxt_bin == '0);
            at_max   <= (nxt_bin == CNT_MAX);
            bound    <= nxt_bound;
        end
    end

    a_gray_view: assert property (
        @(posedge clk) disable iff (!resetn)
        gray_out == (bin_out ^ (bin_out >> 1))
    );

    a_flags_excl: assert property (
        @(posedge clk) disable iff (!resetn)
        !(at_min && at_max)
    );

    a_one_bit_step: assert property (
        @(posedge clk) disable iff (!resetn)
        (en && !clr && !load) |=>
            ($countones($past(gray_out) ^ gray_out) ==
             (($past(bin_out) != bin_out) ? 1 : 0))
    );

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed bench for gray_updown_counter: WIDTH=4 wrap and saturate
// instances plus a WIDTH=8 wrap instance against a modulo-256 model.
module tb_gray_updown_counter;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // wrap instance, WIDTH=4
    logic       w_en = 0, w_up = 0, w_clr = 0, w_load = 0;
    logic [3:0] w_lg = '0;
    logic [3:0] w_gray, w_bin;
    logic       w_min, w_max, w_bound;

    // saturate instance, WIDTH=4
    logic       s_en = 0, s_up = 0, s_clr = 0, s_load = 0;
    logic [3:0] s_lg = '0;
    logic [3:0] s_gray, s_bin;
    logic       s_min, s_max, s_bound;

    // wrap instance, WIDTH=8
    logic       e_en = 0, e_up = 0, e_clr = 0, e_load = 0;
    logic [7:0] e_lg = '0;
    logic [7:0] e_gray, e_bin;
    logic       e_min, e_max, e_bound;

    gray_updown_counter #(.WIDTH(4), .WRAP(1'b1)) u_wrap (
        .clk(clk), .resetn(rstn), .en(w_en), .up(w_up), .clr(w_clr),
        .load(w_load), .load_gray(w_lg), .gray_out(w_gray),
        .bin_out(w_bin), .at_min(w_min), .at_max(w_max), .bound(w_bound)
    );

    gray_updown_counter #(.WIDTH(4), .WRAP(1'b0)) u_sat (
        .clk(clk), .resetn(rstn), .en(s_en), .up(s_up), .clr(s_clr),
        .load(s_load), .load_gray(s_lg), .gray_out(s_gray),
        .bin_out(s_bin), .at_min(s_min), .at_max(s_max), .bound(s_bound)
    );

    gray_updown_counter #(.WIDTH(8), .WRAP(1'b1)) u_w8 (
        .clk(clk), .resetn(rstn), .en(e_en), .up(e_up), .clr(e_clr),
        .load(e_load), .load_gray(e_lg), .gray_out(e_gray),
        .bin_out(e_bin), .at_min(e_min), .at_max(e_max), .bound(e_bound)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Gray sequence of a 4-bit up-count starting after 0, ending on wrap.
    logic [3:0] gseq [16] = '{
        4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001,
        4'b1000, 4'b0000
    };

    int pulses;
    int m;
    int r;
    logic [7:0] lb;
    logic       eb;

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bin", w_bin, 0);
        chk("rst_gray", w_gray, 0);
        chk("rst_min", w_min, 1);
        chk("rst_max", w_max, 0);
        chk("rst_bound", w_bound, 0);
        @(negedge clk);
        rstn = 1'b1;

        // 16 up-steps through the full Gray cycle
        pulses = 0;
        w_en = 1; w_up = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("up_gray%0d", i), w_gray, gseq[i]);
            chk($sformatf("up_bound%0d", i), w_bound, (i == 15));
            if (w_bound) pulses++;
        end
        chk("up_pulses", pulses, 1);

        // down from 0 wraps to max
        w_up = 0;
        tick();
        chk("dn_bin", w_bin, 15);
        chk("dn_gray", w_gray, 4'b1000);
        chk("dn_max", w_max, 1);
        chk("dn_min", w_min, 0);
        chk("dn_bound", w_bound, 1);
        w_en = 0;
        tick();
        chk("hold_bound", w_bound, 0);
        chk("hold_bin", w_bin, 15);

        // clr beats load beats en
        w_load = 1; w_lg = 4'b1101;
        tick();
        chk("ld9_bin", w_bin, 9);
        w_clr = 1; w_load = 1; w_en = 1; w_up = 1; w_lg = 4'b1111;
        tick();
        chk("clr_bin", w_bin, 0);
        chk("clr_gray", w_gray, 0);
        chk("clr_bound", w_bound, 0);
        w_clr = 0;
        w_lg = 4'b0110;
        tick();
        chk("ld_en_bin", w_bin, 4);
        chk("ld_en_gray", w_gray, 4'b0110);
        w_load = 0; w_en = 0;

        // up toggling while idle has no effect
        for (int i = 0; i < 3; i++) begin
            w_up = ~w_up;
            tick();
        end
        chk("idle_bin", w_bin, 4);

        // direction reversal returns to previous count
        w_en = 1; w_up = 1;
        tick();
        chk("rev_up_gray", w_gray, 4'b0111);
        w_up = 0;
        tick();
        chk("rev_dn_bin", w_bin, 4);
        chk("rev_dn_gray", w_gray, 4'b0110);
        w_en = 0;

        // async reset mid-cycle
        w_load = 1; w_lg = 4'b0100;
        tick();
        chk("ld7_bin", w_bin, 7);
        w_load = 0;
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_bin", w_bin, 0);
        chk("arst_gray", w_gray, 0);
        chk("arst_min", w_min, 1);
        chk("arst_max", w_max, 0);
        @(negedge clk);
        rstn = 1'b1;
        w_en = 1; w_up = 1;
        tick();
        chk("post_rst_gray", w_gray, 4'b0001);
        w_en = 0;

        // saturate mode
        s_load = 1; s_lg = 4'b1000;
        tick();
        chk("sat_ld_bin", s_bin, 15);
        chk("sat_ld_max", s_max, 1);
        s_load = 0; s_en = 1; s_up = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sat_hi_bin%0d", i), s_bin, 15);
            chk($sformatf("sat_hi_gray%0d", i), s_gray, 4'b1000);
            chk($sformatf("sat_hi_bound%0d", i), s_bound, 1);
        end
        s_up = 0;
        tick();
        chk("sat_dn_bin", s_bin, 14);
        chk("sat_dn_gray", s_gray, 4'b1001);
        chk("sat_dn_bound", s_bound, 0);
        s_en = 0; s_clr = 1;
        tick();
        s_clr = 0; s_en = 1; s_up = 0;
        tick();
        chk("sat_lo_bin", s_bin, 0);
        chk("sat_lo_min", s_min, 1);
        chk("sat_lo_bound", s_bound, 1);
        s_en = 0;

        // WIDTH=8 random run against a modulo-256 model
        m = 0;
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 15);
            e_clr  = (r == 0);
            e_load = (r == 1);
            e_en   = ($urandom_range(0, 3) != 0);
            e_up   = $urandom_range(0, 1) != 0;
            e_lg   = 8'($urandom);
            eb = 1'b0;
            if (e_clr) begin
                m = 0;
            end else if (e_load) begin
                for (int k = 0; k < 8; k++) begin
                    lb[k] = ^(e_lg >> k);
                end
                m = int'(lb);
            end else if (e_en && e_up) begin
                eb = (m == 255);
                m = (m + 1) % 256;
            end else if (e_en) begin
                eb = (m == 0);
                m = (m + 255) % 256;
            end
            tick();
            chk("rnd_bin", e_bin, m);
            chk("rnd_gray", e_gray, m ^ (m >> 1));
            chk("rnd_bound", e_bound, eb);
        end
        e_en = 0; e_clr = 0; e_load = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
